alu_seq_unit: RTL and testbench
===============================

// Module: alu_seq_unit
// PURPOSE
//   Parametrised, registered successor to the 4-bit combinational ALU. It adds an
//   accumulator, registered Z/N/C/V status, four further ops and a multi-cycle
//   unsigned multiply. A Start/Busy/Done handshake connects it to the TRISC datapath
//   sequencer. Opcodes 000-011 keep the legacy ADD/SUB/AND/XOR encoding.
// PARAMETERS
//   WIDTH   8  operand/result width in bits; must be >= 2
//   MUL_EN  1  1 = op 111 is a WIDTH-cycle multiply; 0 = op 111 is PASS B (1 cycle)
// PORTS
//   Clock   in   1      system clock; all state changes on the rising edge
//   Reset   in   1      synchronous, active-high reset
//   Start   in   1      request; Op/A/B/UseAcc are sampled on the edge where Start=1 and Busy=0
//   Op      in   3      000 ADD, 001 SUB, 010 AND, 011 XOR, 100 OR, 101 SHL, 110 SHR, 111 MUL
//   A       in   WIDTH  operand A
//   B       in   WIDTH  operand B
//   UseAcc  in   1      1 = use the current R register instead of A as operand A
//   R       out  WIDTH  registered result, which is also the accumulator
//   Cout    out  1      registered carry flag
//   OVR     out  1      registered overflow flag
//   Zero    out  1      registered; equals (R == 0)
//   Neg     out  1      registered; equals R[WIDTH-1]
//   Busy    out  1      high while a multiply is in progress
//   Done    out  1      one-cycle pulse in the cycle R and the flags become valid
// BEHAVIOUR
//   Reset: R=0, Cout=0, OVR=0, Zero=0, Neg=0, Busy=0, Done=0, FSM=IDLE.
//     Reset overrides Start and aborts any operation in flight.
//   FSM states: IDLE, MUL.
//     IDLE + Start, Op!=111 or MUL_EN=0 -> result and flags registered at that edge;
//       Done=1 in the next cycle; latency 1; stays IDLE.
//     IDLE + Start, Op=111 and MUL_EN=1 -> MUL, Busy=1; operands latched; product cleared.
//     MUL runs one shift-add step per cycle for WIDTH cycles. On the final step:
//       R and flags are written, Busy drops and Done=1 in the same cycle -> IDLE.
//       Latency is WIDTH+1 cycles from the Start edge.
//   Start while Busy=1 is ignored and not queued. Start in a Done cycle is accepted,
//     so back-to-back ops are allowed.
//   R, Cout and OVR hold their values between operations. Done is 0 except for its pulse.
//   Zero and Neg are always updated together with R.
//   Arithmetic, all modulo 2^WIDTH:
//     ADD: {Cout,R}=A+B; OVR=signed overflow (operand signs equal, result sign differs).
//     SUB: {Cout,R}=A+~B+1, so Cout=1 means no borrow; OVR=signed overflow of A-B.
//     AND/XOR/OR: bitwise; Cout=0, OVR=0.
//     SHL: R=A<<1, LSB=0; Cout=A[W-1]; OVR=A[W-1]^A[W-2].
//     SHR: logical, R=A>>1, MSB=0; Cout=A[0]; OVR=0.
//     MUL: unsigned; R=low WIDTH bits of A*B; Cout=OVR=(high WIDTH bits != 0).
//     PASS B (MUL_EN=0 only): R=B; Cout=0, OVR=0.
//   UseAcc=1: operand A is the R value at the Start edge, including a result that
//     has just completed.
//   Reset during MUL: the next cycle shows reset values; no Done pulse; the partial product is discarded.
// TESTING (WIDTH=8, MUL_EN=1 unless stated)
//   1 Hold Reset 2 cycles, then release -> all outputs 0, Busy=0; Start with Reset high has no effect.
//   2 ADD A=7F B=01 -> next cycle R=80, OVR=1, Cout=0, Neg=1, Zero=0, Done pulses 1 cycle.
//   3 SUB A=05 B=05 -> R=00, Zero=1, Cout=1, OVR=0; SUB A=00 B=01 -> R=FF, Cout=0, Neg=1.
//   4 MUL A=10 B=11 -> Busy for 8 cycles, Done at cycle 9, R=10, Cout=OVR=1;
//     a Start pulse at cycle 3 is ignored.
//   5 ADD 03+04, then Start on the Done cycle with UseAcc=1, ADD B=01 -> R=07, then R=08;
//     SHL of that result -> R=10.
//   6 Assert Reset at MUL cycle 4 -> next cycle R=0, Busy=0, no Done;
//     with MUL_EN=0, Op=111 B=5A -> R=5A, latency 1.

Source files
------------

// File: rtl/alu_seq_unit.sv
// Registered ALU with accumulator, Z/N/C/V status and a shift-add multiply.
// A Start/Busy/Done handshake connects it to the datapath sequencer.
module alu_seq_unit #(
    parameter int WIDTH  = 8,
    parameter bit MUL_EN = 1'b1
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Start,
    input  logic [2:0]       Op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             UseAcc,
    output logic [WIDTH-1:0] R,
    output logic             Cout,
    output logic             OVR,
    output logic             Zero,
    output logic             Neg,
    output logic             Busy,
    output logic             Done
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_XOR = 3'b011;
    localparam logic [2:0] OP_OR  = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_SHR = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [WIDTH-1:0]       r_q, r_d;
    logic                   cout_q, cout_d;
    logic                   ovr_q, ovr_d;
    logic                   zero_q, zero_d;
    logic                   neg_q, neg_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic [2*WIDTH-1:0]     acc_q, acc_d;
    logic [2*WIDTH-1:0]     mcand_q, mcand_d;
    logic [WIDTH-1:0]       mplier_q, mplier_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;

    logic [WIDTH-1:0]       op_a_s;
    logic [WIDTH:0]         sum_s;
    logic [WIDTH:0]         diff_s;
    logic [WIDTH-1:0]       alu_r_s;
    logic                   alu_c_s;
    logic                   alu_v_s;
    logic [2*WIDTH-1:0]     acc_step_s;
    logic                   is_mul_s;

    // Single-cycle datapath; operand A may come from the accumulator.
    always_comb begin
        if (UseAcc) begin
            op_a_s = r_q;
        end else begin
            op_a_s = A;
        end
        sum_s   = {1'b0, op_a_s} + {1'b0, B};
        diff_s  = {1'b0, op_a_s} + {1'b0, ~B} + {{WIDTH{1'b0}}, 1'b1};
        alu_r_s = {WIDTH{1'b0}};
        alu_c_s = 1'b0;
        alu_v_s = 1'b0;
        case (Op)
            OP_ADD: begin
                alu_r_s = sum_s[WIDTH-1:0];
                alu_c_s = sum_s[WIDTH];
                alu_v_s = (op_a_s[WIDTH-1] == B[WIDTH-1]) &&
                          (sum_s[WIDTH-1] != op_a_s[WIDTH-1]);
            end
            OP_SUB: begin
                alu_r_s = diff_s[WIDTH-1:0];
                alu_c_s = diff_s[WIDTH];
                alu_v_s = (op_a_s[WIDTH-1] != B[WIDTH-1]) &&
                          (diff_s[WIDTH-1] != op_a_s[WIDTH-1]);
            end
            OP_AND: alu_r_s = op_a_s & B;
            OP_XOR: alu_r_s = op_a_s ^ B;
            OP_OR:  alu_r_s = op_a_s | B;
            OP_SHL: begin
                alu_r_s = {op_a_s[WIDTH-2:0], 1'b0};
                alu_c_s = op_a_s[WIDTH-1];
                alu_v_s = op_a_s[WIDTH-1] ^ op_a_s[WIDTH-2];
            end
            OP_SHR: begin
                alu_r_s = {1'b0, op_a_s[WIDTH-1:1]};
                alu_c_s = op_a_s[0];
            end
            OP_MUL: alu_r_s = B;
            default: begin
                alu_r_s = {WIDTH{1'b0}};
                alu_c_s = 1'b0;
                alu_v_s = 1'b0;
            end
        endcase
    end

    // Sequencer: next-state, multiply step and result/flag update.
    always_comb begin
        state_d    = state_q;
        r_d        = r_q;
        cout_d     = cout_q;
        ovr_d      = ovr_q;
        zero_d     = zero_q;
        neg_d      = neg_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        acc_d      = acc_q;
        mcand_d    = mcand_q;
        mplier_d   = mplier_q;
        cnt_d      = cnt_q;
        is_mul_s   = (Op == OP_MUL) && (MUL_EN == 1'b1);
        if (mplier_q[0]) begin
            acc_step_s = acc_q + mcand_q;
        end else begin
            acc_step_s = acc_q;
        end
        case (state_q)
            ST_IDLE: begin
                if (Start && is_mul_s) begin
                    state_d  = ST_MUL;
                    busy_d   = 1'b1;
                    acc_d    = {(2*WIDTH){1'b0}};
                    mcand_d  = {{WIDTH{1'b0}}, op_a_s};
                    mplier_d = B;
                    cnt_d    = {CNT_W{1'b0}};
                end else if (Start) begin
                    r_d    = alu_r_s;
                    cout_d = alu_c_s;
                    ovr_d  = alu_v_s;
                    zero_d = (alu_r_s == {WIDTH{1'b0}});
                    neg_d  = alu_r_s[WIDTH-1];
                    done_d = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_MUL: begin
                acc_d    = acc_step_s;
                mcand_d  = {mcand_q[2*WIDTH-2:0], 1'b0};
                mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    // Final step commits the product in the same cycle Busy falls.
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    r_d     = acc_step_s[WIDTH-1:0];
                    cout_d  = |acc_step_s[2*WIDTH-1:WIDTH];
                    ovr_d   = |acc_step_s[2*WIDTH-1:WIDTH];
                    zero_d  = (acc_step_s[WIDTH-1:0] == {WIDTH{1'b0}});
                    neg_d   = acc_step_s[WIDTH-1];
                    done_d  = 1'b1;
                end else begin
                    state_d = ST_MUL;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q  <= ST_IDLE;
            r_q      <= {WIDTH{1'b0}};
            cout_q   <= 1'b0;
            ovr_q    <= 1'b0;
            zero_q   <= 1'b0;
            neg_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            acc_q    <= {(2*WIDTH){1'b0}};
            mcand_q  <= {(2*WIDTH){1'b0}};
            mplier_q <= {WIDTH{1'b0}};
            cnt_q    <= {CNT_W{1'b0}};
        end else begin
            state_q  <= state_d;
            r_q      <= r_d;
            cout_q   <= cout_d;
            ovr_q    <= ovr_d;
            zero_q   <= zero_d;
            neg_q    <= neg_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
        end
    end

    assign R    = r_q;
    assign Cout = cout_q;
    assign OVR  = ovr_q;
    assign Zero = zero_q;
    assign Neg  = neg_q;
    assign Busy = busy_q;
    assign Done = done_q;

endmodule

// File: tb/tb_alu_seq_unit.sv
// Directed bench for alu_seq_unit: one instance with the multiplier, one with
// op 111 as PASS B; all expected values are hand-computed constants.
module tb_alu_seq_unit;

    logic       Clock;
    logic       Reset;
    logic       Start;
    logic [2:0] Op;
    logic [7:0] A;
    logic [7:0] B;
    logic       UseAcc;

    logic [7:0] r_s, r0_s;
    logic       cout_s, ovr_s, zero_s, neg_s, busy_s, done_s;
    logic       cout0_s, ovr0_s, zero0_s, neg0_s, busy0_s, done0_s;

    int n_checks = 0;
    int n_errors = 0;

    alu_seq_unit #(.WIDTH(8), .MUL_EN(1'b1)) dut (
        .Clock(Clock), .Reset(Reset), .Start(Start), .Op(Op), .A(A), .B(B),
        .UseAcc(UseAcc), .R(r_s), .Cout(cout_s), .OVR(ovr_s), .Zero(zero_s),
        .Neg(neg_s), .Busy(busy_s), .Done(done_s)
    );

    alu_seq_unit #(.WIDTH(8), .MUL_EN(1'b0)) dut_nomul (
        .Clock(Clock), .Reset(Reset), .Start(Start), .Op(Op), .A(A), .B(B),
        .UseAcc(UseAcc), .R(r0_s), .Cout(cout0_s), .OVR(ovr0_s), .Zero(zero0_s),
        .Neg(neg0_s), .Busy(busy0_s), .Done(done0_s)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    // Flags as {Cout, OVR, Zero, Neg, Busy, Done}
    function automatic logic [5:0] flags();
        return {cout_s, ovr_s, zero_s, neg_s, busy_s, done_s};
    endfunction

    task automatic run_op(input string tag, input logic [2:0] op, input logic [7:0] a,
                          input logic [7:0] b, input logic use_acc,
                          input logic [7:0] exp_r, input logic [3:0] exp_cvzn);
        Start = 1'b1; Op = op; A = a; B = b; UseAcc = use_acc;
        tick();
        Start = 1'b0; UseAcc = 1'b0;
        check_val({tag, "_r"}, r_s, exp_r);
        check_val({tag, "_flags"}, flags(), {exp_cvzn, 2'b01});
    endtask

    task automatic run_mul(input string tag, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] exp_r, input logic [3:0] exp_cvzn);
        Start = 1'b1; Op = 3'b111; A = a; B = b; UseAcc = 1'b0;
        tick();
        for (int i = 1; i <= 8; i++) begin
            check_val($sformatf("%s_busy%0d", tag, i), {busy_s, done_s}, 2'b10);
            // A stray ADD request mid-multiply must be dropped.
            if (i == 3) begin
                Start = 1'b1; Op = 3'b000; A = 8'h01; B = 8'h01;
            end else begin
                Start = 1'b0;
            end
            tick();
        end
        check_val({tag, "_r"}, r_s, exp_r);
        check_val({tag, "_flags"}, flags(), {exp_cvzn, 2'b01});
        tick();
        check_val({tag, "_after"}, {r_s, busy_s, done_s}, {exp_r, 2'b00});
    endtask

    initial begin
        Reset = 1'b1; Start = 1'b1; Op = 3'b000; A = 8'h01; B = 8'h01; UseAcc = 1'b0;
        tick();
        tick();
        check_val("reset_with_start", {r_s, flags()}, 14'h0);
        Reset = 1'b0; Start = 1'b0;
        tick();
        check_val("reset_release", {r_s, flags()}, 14'h0);

        run_op("add_7f_01", 3'b000, 8'h7F, 8'h01, 1'b0, 8'h80, 4'b0101);
        tick();
        check_val("done_drop", {r_s, done_s}, {8'h80, 1'b0});

        run_op("sub_05_05", 3'b001, 8'h05, 8'h05, 1'b0, 8'h00, 4'b1010);
        run_op("sub_00_01", 3'b001, 8'h00, 8'h01, 1'b0, 8'hFF, 4'b0001);

        run_mul("mul_10_11", 8'h10, 8'h11, 8'h10, 4'b1100);
        run_mul("mul_0f_0f", 8'h0F, 8'h0F, 8'hE1, 4'b0001);

        run_op("add_03_04", 3'b000, 8'h03, 8'h04, 1'b0, 8'h07, 4'b0000);
        run_op("acc_add_01", 3'b000, 8'hFF, 8'h01, 1'b1, 8'h08, 4'b0000);
        run_op("acc_shl", 3'b101, 8'h00, 8'h00, 1'b1, 8'h10, 4'b0000);

        run_op("add_ff_01", 3'b000, 8'hFF, 8'h01, 1'b0, 8'h00, 4'b1010);
        run_op("and", 3'b010, 8'hF0, 8'h3C, 1'b0, 8'h30, 4'b0000);
        run_op("xor", 3'b011, 8'hF0, 8'h3C, 1'b0, 8'hCC, 4'b0001);
        run_op("or", 3'b100, 8'hF0, 8'h3C, 1'b0, 8'hFC, 4'b0001);
        run_op("shl_c0", 3'b101, 8'hC0, 8'h00, 1'b0, 8'h80, 4'b1001);
        run_op("shl_40", 3'b101, 8'h40, 8'h00, 1'b0, 8'h80, 4'b0101);
        run_op("shr_81", 3'b110, 8'h81, 8'h00, 1'b0, 8'h40, 4'b1000);
        run_op("sub_80_01", 3'b001, 8'h80, 8'h01, 1'b0, 8'h7F, 4'b1100);

        // Abort a multiply at cycle 4 with reset.
        Start = 1'b1; Op = 3'b111; A = 8'h12; B = 8'h34;
        tick();
        Start = 1'b0;
        tick();
        tick();
        tick();
        check_val("abort_busy", busy_s, 1'b1);
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        check_val("abort_reset", {r_s, flags()}, 14'h0);
        for (int i = 0; i < 8; i++) begin
            tick();
            check_val($sformatf("abort_quiet%0d", i), {r_s, busy_s, done_s}, 10'h0);
        end

        // Op 111 on both instances: PASS B versus multiply.
        Start = 1'b1; Op = 3'b111; A = 8'h03; B = 8'h5A;
        tick();
        Start = 1'b0;
        check_val("pass_b_r", r0_s, 8'h5A);
        check_val("pass_b_flags", {cout0_s, ovr0_s, zero0_s, neg0_s, busy0_s, done0_s}, 6'b000001);
        check_val("mul_en_busy", {busy_s, done_s}, 2'b10);
        tick();
        check_val("pass_b_done_drop", done0_s, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
